// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with sync clear/load, wrap or saturate at the
// bounds, a one-cycle bound pulse, a sticky bad-load flag and a max-state detect.
module updown_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int HIT_REG  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             hit,
    output logic             wrap,
    output logic             err
);

    // Top count as a WIDTH-bit constant, so MODULUS == 2**WIDTH never overflows.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             err_next;
    logic             at_max;

    assign at_max = (count == MAX_VAL);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        count_next = count;
        wrap_next  = 1'b0;
        err_next   = err;
        if (clr) begin
            count_next = '0;
            err_next   = 1'b0;
        end else if (load) begin
            // load_val > MAX_VAL is load_val >= MODULUS without a wider compare.
            if (load_val > MAX_VAL) begin
                count_next = MAX_VAL;
                err_next   = 1'b1;
            end else begin
                count_next = load_val;
            end
        end else if (en) begin
            if (!dir) begin
                if (at_max) begin
                    wrap_next  = 1'b1;
                    count_next = (SATURATE != 0) ? count : '0;
                end else begin
                    count_next = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    wrap_next  = 1'b1;
                    count_next = (SATURATE != 0) ? count : MAX_VAL;
                end else begin
                    count_next = count - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
            err   <= err_next;
        end
    end

    generate
        if (HIT_REG != 0) begin : g_hit_reg
            // Deliberately ungated: hit follows the pre-edge count on every edge.
            logic hit_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) hit_q <= 1'b0;
                else        hit_q <= at_max;
            end
            assign hit = hit_q;
        end else begin : g_hit_comb
            assign hit = at_max;
        end
    endgenerate

endmodule
